// File: rtl/uart1_tx_arb.sv
// uart1_tx_arb: frame-atomic round-robin arbiter that shares the UART1 TX FIFO
// write port between two byte-stream frame producers (src0, src1).
//
// Handshake: a byte transfers on a clock edge where srcN_wen and srcN_ready are
// both high (wen acts as valid). A source that sees ready low holds wen, wdata
// and last steady until ready returns. A wen strobe without ready is dropped
// and counted; it is not queued.
module uart1_tx_arb #(
  parameter logic [11:0] THRESH  = 12'd2000,
  parameter logic [15:0] TIMEOUT = 16'd50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        src0_req,
  input  logic        src0_wen,
  input  logic [7:0]  src0_wdata,
  input  logic        src0_last,
  input  logic        src1_req,
  input  logic        src1_wen,
  input  logic [7:0]  src1_wdata,
  input  logic        src1_last,
  output logic        src0_gnt,
  output logic        src1_gnt,
  output logic        src0_ready,
  output logic        src1_ready,
  output logic        tx_fifo_wen,
  output logic [7:0]  tx_fifo_wdata,
  input  logic        tx_fifo_full,
  input  logic [11:0] tx_fifo_usedw,
  output logic        timeout_err,
  output logic [15:0] drop_cnt,
  output logic [1:0]  dbg_state
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } state_t;

  state_t      state;
  state_t      next_state;
  logic        last_owner;   // 0: src0 owned the last frame, 1: src1
  logic        next_owner;
  logic [15:0] idle_cnt;
  logic [15:0] next_idle;
  logic        fire_timeout;
  logic        space;
  logic        acc0;
  logic        acc1;
  logic        drop0;
  logic        drop1;
  logic [16:0] drop_sum;
  logic [15:0] next_drop;

  // FIFO has room when not full and below the hold-off threshold.
  assign space      = !tx_fifo_full && (tx_fifo_usedw < THRESH);
  assign src0_ready = src0_gnt & space;
  assign src1_ready = src1_gnt & space;

  // Ready already implies ownership, so these are the accepted bytes.
  assign acc0  = src0_wen & src0_ready;
  assign acc1  = src1_wen & src1_ready;
  assign drop0 = src0_wen & ~acc0;
  assign drop1 = src1_wen & ~acc1;

  assign dbg_state = state;

  // Saturating add of 0, 1 or 2 dropped strobes this cycle.
  always_comb begin
    drop_sum  = {1'b0, drop_cnt} + 17'(drop0) + 17'(drop1);
    next_drop = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
  end

  // Next state: round-robin pick in IDLE, release on accepted last or idle timeout.
  always_comb begin
    next_state   = state;
    next_owner   = last_owner;
    next_idle    = idle_cnt;
    fire_timeout = 1'b0;
    case (state)
      IDLE: begin
        next_idle = 16'd0;
        if (src0_req && !src1_req) begin
          next_state = GNT0;
        end else if (src1_req && !src0_req) begin
          next_state = GNT1;
        end else if (src0_req && src1_req) begin
          next_state = last_owner ? GNT0 : GNT1;
        end
      end
      GNT0: begin
        if (acc0) begin
          next_idle = 16'd0;
          if (src0_last) begin
            next_state = IDLE;
            next_owner = 1'b0;
          end
        end else if (idle_cnt == TIMEOUT - 16'd1) begin
          next_state   = IDLE;
          next_owner   = 1'b0;
          next_idle    = 16'd0;
          fire_timeout = 1'b1;
        end else begin
          next_idle = idle_cnt + 16'd1;
        end
      end
      GNT1: begin
        if (acc1) begin
          next_idle = 16'd0;
          if (src1_last) begin
            next_state = IDLE;
            next_owner = 1'b1;
          end
        end else if (idle_cnt == TIMEOUT - 16'd1) begin
          next_state   = IDLE;
          next_owner   = 1'b1;
          next_idle    = 16'd0;
          fire_timeout = 1'b1;
        end else begin
          next_idle = idle_cnt + 16'd1;
        end
      end
      default: begin
        next_state = IDLE;
        next_idle  = 16'd0;
      end
    endcase
  end

  // State, registered grants, forwarded byte stage and counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      last_owner    <= 1'b1;
      src0_gnt      <= 1'b0;
      src1_gnt      <= 1'b0;
      idle_cnt      <= 16'd0;
      timeout_err   <= 1'b0;
      tx_fifo_wen   <= 1'b0;
      tx_fifo_wdata <= 8'h00;
      drop_cnt      <= 16'd0;
    end else begin
      state       <= next_state;
      last_owner  <= next_owner;
      src0_gnt    <= (next_state == GNT0);
      src1_gnt    <= (next_state == GNT1);
      idle_cnt    <= next_idle;
      timeout_err <= fire_timeout;
      tx_fifo_wen <= acc0 | acc1;
      if (acc0) begin
        tx_fifo_wdata <= src0_wdata;
      end else if (acc1) begin
        tx_fifo_wdata <= src1_wdata;
      end
      drop_cnt <= next_drop;
    end
  end

endmodule

// File: tb/tb_uart1_tx_arb.sv
// Directed bench for uart1_tx_arb (TIMEOUT overridden to 100).
module tb_uart1_tx_arb;

  logic        clk;
  logic        rst;
  logic        src0_req;
  logic        src0_wen;
  logic [7:0]  src0_wdata;
  logic        src0_last;
  logic        src1_req;
  logic        src1_wen;
  logic [7:0]  src1_wdata;
  logic        src1_last;
  logic        src0_gnt;
  logic        src1_gnt;
  logic        src0_ready;
  logic        src1_ready;
  logic        tx_fifo_wen;
  logic [7:0]  tx_fifo_wdata;
  logic        tx_fifo_full;
  logic [11:0] tx_fifo_usedw;
  logic        timeout_err;
  logic [15:0] drop_cnt;
  logic [1:0]  dbg_state;

  int n_cmp;
  int n_mis;

  uart1_tx_arb #(
    .THRESH (12'd2000),
    .TIMEOUT(16'd100)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .src0_req     (src0_req),
    .src0_wen     (src0_wen),
    .src0_wdata   (src0_wdata),
    .src0_last    (src0_last),
    .src1_req     (src1_req),
    .src1_wen     (src1_wen),
    .src1_wdata   (src1_wdata),
    .src1_last    (src1_last),
    .src0_gnt     (src0_gnt),
    .src1_gnt     (src1_gnt),
    .src0_ready   (src0_ready),
    .src1_ready   (src1_ready),
    .tx_fifo_wen  (tx_fifo_wen),
    .tx_fifo_wdata(tx_fifo_wdata),
    .tx_fifo_full (tx_fifo_full),
    .tx_fifo_usedw(tx_fifo_usedw),
    .timeout_err  (timeout_err),
    .drop_cnt     (drop_cnt),
    .dbg_state    (dbg_state)
  );

  // Clock: 10 ns period, posedges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; land 2 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    #3;
    rst = 1'b1;
  endtask

  // Send n bytes back-to-back from a granted source, last on the final byte.
  // Each byte must see ready, be written to the FIFO one edge later, and the
  // other grant must stay low. After the final byte the grant must be gone.
  task automatic send_frame(input int src, input int n, input logic [7:0] base);
    for (int i = 0; i < n; i++) begin
      if (src == 0) begin
        src0_wen = 1'b1; src0_wdata = base + 8'(i); src0_last = (i == n - 1);
        #1;
        chk("frame_ready0", {31'd0, src0_ready}, 32'd1);
      end else begin
        src1_wen = 1'b1; src1_wdata = base + 8'(i); src1_last = (i == n - 1);
        #1;
        chk("frame_ready1", {31'd0, src1_ready}, 32'd1);
      end
      tick();
      chk("frame_wen", {31'd0, tx_fifo_wen}, 32'd1);
      chk("frame_wdata", {24'd0, tx_fifo_wdata}, {24'd0, base + 8'(i)});
      if (src == 0) chk("frame_no_overlap1", {31'd0, src1_gnt}, 32'd0);
      else          chk("frame_no_overlap0", {31'd0, src0_gnt}, 32'd0);
    end
    src0_wen = 1'b0; src0_last = 1'b0;
    src1_wen = 1'b0; src1_last = 1'b0;
    chk("frame_end_gnt0", {31'd0, src0_gnt}, 32'd0);
    chk("frame_end_gnt1", {31'd0, src1_gnt}, 32'd0);
  endtask

  initial begin
    n_cmp = 0;
    n_mis = 0;
    rst = 1'b0;
    src0_req = 1'b0; src0_wen = 1'b0; src0_wdata = 8'h00; src0_last = 1'b0;
    src1_req = 1'b0; src1_wen = 1'b0; src1_wdata = 8'h00; src1_last = 1'b0;
    tx_fifo_full = 1'b0;
    tx_fifo_usedw = 12'd0;

    // Reset values
    #12;
    chk("rst_gnt0", {31'd0, src0_gnt}, 32'd0);
    chk("rst_gnt1", {31'd0, src1_gnt}, 32'd0);
    chk("rst_wen", {31'd0, tx_fifo_wen}, 32'd0);
    chk("rst_wdata", {24'd0, tx_fifo_wdata}, 32'h00);
    chk("rst_terr", {31'd0, timeout_err}, 32'd0);
    chk("rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("rst_state", {30'd0, dbg_state}, 32'd0);
    rst = 1'b1;
    tick();

    // Single src0 16-byte frame
    src0_req = 1'b1;
    tick();
    chk("t1_gnt0", {31'd0, src0_gnt}, 32'd1);
    chk("t1_gnt1", {31'd0, src1_gnt}, 32'd0);
    chk("t1_state", {30'd0, dbg_state}, 32'd1);
    src0_req = 1'b0;
    send_frame(0, 16, 8'h10);
    tick();
    chk("t1_wen_idle", {31'd0, tx_fifo_wen}, 32'd0);
    chk("t1_wdata_hold", {24'd0, tx_fifo_wdata}, 32'h1F);

    // Contention from reset: src0, src1, src0, src1 with one IDLE cycle between
    do_reset();
    src0_req = 1'b1;
    src1_req = 1'b1;
    tick();
    chk("t2_first_gnt0", {31'd0, src0_gnt}, 32'd1);
    chk("t2_first_gnt1", {31'd0, src1_gnt}, 32'd0);
    send_frame(0, 8, 8'h20);
    tick();
    chk("t2_f2_gnt1", {31'd0, src1_gnt}, 32'd1);
    chk("t2_f2_gnt0", {31'd0, src0_gnt}, 32'd0);
    send_frame(1, 8, 8'h30);
    tick();
    chk("t2_f3_gnt0", {31'd0, src0_gnt}, 32'd1);
    chk("t2_f3_gnt1", {31'd0, src1_gnt}, 32'd0);
    send_frame(0, 8, 8'h40);
    tick();
    chk("t2_f4_gnt1", {31'd0, src1_gnt}, 32'd1);
    chk("t2_f4_gnt0", {31'd0, src0_gnt}, 32'd0);
    send_frame(1, 8, 8'h50);
    src0_req = 1'b0;
    src1_req = 1'b0;
    tick();

    // Backpressure: threshold and full
    src0_req = 1'b1;
    tick();
    chk("t3_gnt0", {31'd0, src0_gnt}, 32'd1);
    tx_fifo_usedw = 12'd2000;
    #1;
    chk("t3_ready_at_thresh", {31'd0, src0_ready}, 32'd0);
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("t3_stall_wen", {31'd0, tx_fifo_wen}, 32'd0);
    end
    tx_fifo_usedw = 12'd0;
    tx_fifo_full = 1'b1;
    #1;
    chk("t3_ready_full", {31'd0, src0_ready}, 32'd0);
    tx_fifo_full = 1'b0;
    tx_fifo_usedw = 12'd1999;
    #1;
    chk("t3_ready_below", {31'd0, src0_ready}, 32'd1);
    src0_req = 1'b0;
    send_frame(0, 4, 8'h60);
    chk("t3_drop_none", {16'd0, drop_cnt}, 32'd0);
    tx_fifo_usedw = 12'd0;
    tick();

    // Drops: 3 from ungranted src1, 1 from src0 at threshold, then 2 at once
    src0_req = 1'b1;
    tick();
    chk("t4_gnt0", {31'd0, src0_gnt}, 32'd1);
    src0_req = 1'b0;
    src1_wen = 1'b1;
    src1_wdata = 8'hA5;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("t4_src1_drop_wen", {31'd0, tx_fifo_wen}, 32'd0);
    end
    src1_wen = 1'b0;
    tx_fifo_usedw = 12'd2000;
    src0_wen = 1'b1;
    src0_wdata = 8'h77;
    tick();
    chk("t4_src0_drop_wen", {31'd0, tx_fifo_wen}, 32'd0);
    chk("t4_drop4", {16'd0, drop_cnt}, 32'd4);
    src1_wen = 1'b1;
    tick();
    chk("t4_dual_wen", {31'd0, tx_fifo_wen}, 32'd0);
    chk("t4_drop6", {16'd0, drop_cnt}, 32'd6);
    chk("t4_still_gnt0", {31'd0, src0_gnt}, 32'd1);
    src0_wen = 1'b0;
    src1_wen = 1'b0;
    tx_fifo_usedw = 12'd0;
    send_frame(0, 1, 8'h80);
    tick();

    // Timeout: src1 stalls after 2 bytes, src0 waiting
    src1_req = 1'b1;
    tick();
    chk("t5_gnt1", {31'd0, src1_gnt}, 32'd1);
    src1_wen = 1'b1;
    for (int i = 0; i < 2; i++) begin
      src1_wdata = 8'hC0 + 8'(i);
      tick();
      chk("t5_byte_wdata", {24'd0, tx_fifo_wdata}, {24'd0, 8'hC0 + 8'(i)});
    end
    src1_wen = 1'b0;
    src1_req = 1'b0;
    src0_req = 1'b1;
    for (int k = 1; k < 100; k++) begin
      tick();
      if (src1_gnt !== 1'b1 || timeout_err !== 1'b0) begin
        chk("t5_hold_gnt1", {31'd0, src1_gnt}, 32'd1);
        chk("t5_hold_terr", {31'd0, timeout_err}, 32'd0);
      end
    end
    chk("t5_pre_gnt1", {31'd0, src1_gnt}, 32'd1);
    tick();
    chk("t5_release_gnt1", {31'd0, src1_gnt}, 32'd0);
    chk("t5_terr_pulse", {31'd0, timeout_err}, 32'd1);
    chk("t5_release_gnt0", {31'd0, src0_gnt}, 32'd0);
    tick();
    chk("t5_next_gnt0", {31'd0, src0_gnt}, 32'd1);
    chk("t5_terr_clear", {31'd0, timeout_err}, 32'd0);
    src0_req = 1'b0;
    send_frame(0, 2, 8'h90);
    tick();

    // Reset mid-frame
    src0_req = 1'b1;
    tick();
    chk("t6_gnt0", {31'd0, src0_gnt}, 32'd1);
    src0_wen = 1'b1;
    src0_wdata = 8'hE1;
    tick();
    chk("t6_wen_before", {31'd0, tx_fifo_wen}, 32'd1);
    rst = 1'b0;
    #1;
    chk("t6_rst_gnt0", {31'd0, src0_gnt}, 32'd0);
    chk("t6_rst_wen", {31'd0, tx_fifo_wen}, 32'd0);
    chk("t6_rst_wdata", {24'd0, tx_fifo_wdata}, 32'h00);
    chk("t6_rst_drop", {16'd0, drop_cnt}, 32'd0);
    chk("t6_rst_state", {30'd0, dbg_state}, 32'd0);
    src0_wen = 1'b0;
    src1_req = 1'b1;
    rst = 1'b1;
    tick();
    chk("t6_after_gnt0", {31'd0, src0_gnt}, 32'd1);
    chk("t6_after_gnt1", {31'd0, src1_gnt}, 32'd0);
    src0_req = 1'b0;
    src1_req = 1'b0;
    send_frame(0, 1, 8'hF0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/uart1_tx_arb.md
# uart1_tx_arb

Frame-atomic round-robin arbiter sharing the single UART1 transmit FIFO between two byte-stream frame producers (src0: pulse-measurement frame builder; src1: status/reply frame builder). Grants one source at a time for a whole frame, forwards its bytes to the FIFO write port with one registered stage, applies FIFO-level backpressure, and reclaims the grant from a stalled source by timeout.

## Interface
- `THRESH`, 12'd2000: FIFO fill level at or above which sources are held off.
- `TIMEOUT`, 16'd50000: idle cycles inside a granted frame before forced release.
- `clk`  in  1  system clock; single clock domain.
- `rst`  in  1  asynchronous, active-low reset.
- `src0_req`, `src1_req`  in  1  level; source has a frame pending.
- `src0_wen`, `src1_wen`  in  1  byte strobe.
- `src0_wdata`, `src1_wdata`  in  8  byte.
- `src0_last`, `src1_last`  in  1  qualifies wen: final byte of frame.
- `src0_gnt`, `src1_gnt`  out  1  registered grant; at most one high.
- `src0_ready`, `src1_ready`  out  1  combinational: own gnt & space available.
- `tx_fifo_wen`  out  1  FIFO write strobe.
- `tx_fifo_wdata`  out  8  FIFO write data.
- `tx_fifo_full`  in  1  FIFO full.
- `tx_fifo_usedw`  in  12  FIFO fill level.
- `timeout_err`  out  1  one-cycle pulse on forced release.
- `drop_cnt`  out  16  saturating count of discarded bytes.

## Operation
- State machine: IDLE, GNT0, GNT1. `last_owner` register (reset 1, so src0 wins first).
- IDLE: if exactly one req high, go to that GNTn; if both, go to GNT of source != last_owner; else stay.
- `srcN_gnt` = (state == GNTn), registered; asserts the cycle after the request is seen in IDLE.
- `space` = !tx_fifo_full & (tx_fifo_usedw < THRESH). `srcN_ready` = srcN_gnt & space.
- Accepted byte: srcN_wen & srcN_ready in GNTn. Registered next cycle: tx_fifo_wen=1, tx_fifo_wdata=srcN_wdata. Otherwise tx_fifo_wen=0, wdata holds last value.
- Dropped byte: any srcN_wen not accepted (not granted, or granted with space=0). drop_cnt += 1 per dropped strobe, saturates at 16'hFFFF; both sources dropping same cycle counts 2 (saturating).
- Frame end: accepted byte with srcN_last -> next state IDLE, last_owner=N. A last on a dropped byte does not end the frame.
- Idle counter (16 bit): clears on entry to GNTn and on every accepted byte; increments otherwise while in GNTn. Reaching TIMEOUT-1 -> next state IDLE, last_owner=N, timeout_err pulses one cycle (coincident with gnt deassertion).
- Request deasserted mid-grant does not release; only last or timeout.

## Timing
- Reset values: all gnt 0, tx_fifo_wen 0, tx_fifo_wdata 8'h00, timeout_err 0, drop_cnt 0, state IDLE, idle counter 0, last_owner 1.
- Source byte to FIFO strobe: 1 cycle latency, 1 byte/cycle sustained.
- Request to grant: 1 cycle from IDLE. Frame end to next grant: 2 cycles minimum (one IDLE cycle), so consecutive frames from contending sources always alternate.
- Backpressure: ready drops combinationally in the same cycle usedw reaches THRESH or full asserts; source holds its byte until ready returns. Up to one in-flight byte may land after THRESH is crossed; THRESH must leave at least 2 entries of headroom below FIFO depth.
- usedw == THRESH-1 -> space; usedw == THRESH -> no space.
- Reset mid-frame: gnt, wen drop immediately (async); partial frame is not completed; counters clear.

## Test plan
- Reset then src0_req only, 16-byte frame with last on byte 16 -> src0_gnt 1 cycle after req, 16 tx_fifo_wen pulses each 1 cycle after src0_wen, data matches, gnt low cycle after byte 16.
- Both req high simultaneously from reset, 8-byte frames each, repeated -> order src0, src1, src0, src1; exactly one IDLE cycle between frames; gnts never overlap.
- Hold tx_fifo_usedw=2000 during src0 frame -> src0_ready 0, no FIFO writes; stall with wen=0; drop to 1999 -> transfer resumes, all bytes delivered once.
- src1 writes 3 bytes while src0 granted, then src0 writes 1 byte while usedw=2000 -> drop_cnt=4, no FIFO writes from those strobes.
- Granted src1 stops after 2 bytes, TIMEOUT=100 -> gnt drops and timeout_err pulses 100 cycles after the last accepted byte; pending src0 granted 1 cycle later.
- Assert rst low mid-frame -> all outputs to reset values immediately; after release, src0 wins a simultaneous request.
